// File: rtl/sdram_traffic_gen.sv
// Write/read-back traffic generator and checker for the sdram_controller request/ack port.
// Optional latency statistics ports are enabled by defining SDRAM_TG_LAT_STATS_EN.
module sdram_traffic_gen #(
    parameter int                         FPGA_ADDR_WIDTH = 23,
    parameter int                         FPGA_DATA_WIDTH = 32,
    parameter int                         NUM_WORDS       = 16,
    parameter logic [FPGA_ADDR_WIDTH-1:0] START_ADDR      = '0,
    parameter int                         ADDR_STRIDE     = 1,
    parameter int                         IDLE_GAP        = 4,
    parameter int                         TIMEOUT         = 4096,
    parameter logic [31:0]                PATTERN_BASE    = 32'h0000FF01,
    localparam int                        EW              = $clog2(NUM_WORDS + 1),
    localparam int                        LW              = $clog2(TIMEOUT + 1)
) (
    input  logic                       fpga_clk,
    input  logic                       fpga_reset,
    input  logic                       start,
    input  logic [1:0]                 mode,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [EW-1:0]              err_count,
    output logic [FPGA_ADDR_WIDTH-1:0] first_err_addr,
    output logic [FPGA_DATA_WIDTH-1:0] first_err_data,
`ifdef SDRAM_TG_LAT_STATS_EN
    output logic [LW-1:0]              max_latency,
    output logic [31:0]                total_cycles,
`endif
    output logic [FPGA_ADDR_WIDTH-1:0] fpga_addr,
    output logic                       fpga_wr_en,
    output logic [FPGA_DATA_WIDTH-1:0] fpga_wr_data,
    output logic                       fpga_rd_en,
    output logic                       fpga_req,
    input  logic                       fpga_ack,
    input  logic [FPGA_DATA_WIDTH-1:0] fpga_rd_data
);
    localparam int AW  = FPGA_ADDR_WIDTH;
    localparam int DW  = FPGA_DATA_WIDTH;
    localparam int GAP = (IDLE_GAP < 1) ? 1 : IDLE_GAP;
    localparam int GW  = $clog2(GAP + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_REQ = 3'd1;
    localparam logic [2:0] S_WR_GAP = 3'd2;
    localparam logic [2:0] S_RD_REQ = 3'd3;
    localparam logic [2:0] S_RD_GAP = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state;
    logic [1:0]    mode_q;
    logic [EW-1:0] k;
    logic [GW-1:0] gap_cnt;
    logic [LW-1:0] lat_cnt;

    logic [EW-1:0] k_next;
    logic [AW-1:0] addr_next;
    logic [DW-1:0] expected;
    logic          last_word, tmo_hit, accept, ack_take;

    function automatic logic [DW-1:0] pattern(input logic [1:0] m, input logic [EW-1:0] kk,
                                              input logic [AW-1:0] a);
        case (m)
            2'd0:    pattern = DW'(PATTERN_BASE) + DW'(kk);
            2'd1:    pattern = DW'(a);
            2'd2:    pattern = DW'(1) << (32'(kk) % DW);
            default: pattern = kk[0] ? {(DW/2){2'b01}} : {(DW/2){2'b10}};
        endcase
    endfunction

    always_comb begin
        k_next    = k + EW'(1);
        addr_next = fpga_addr + AW'(ADDR_STRIDE);
        expected  = pattern(mode_q, k, fpga_addr);
        last_word = (32'(k) == NUM_WORDS - 1);
        tmo_hit   = (lat_cnt == LW'(TIMEOUT - 1));
        accept    = start && ((state == S_IDLE) || (state == S_DONE));
        ack_take  = fpga_ack && ((state == S_WR_REQ) || (state == S_RD_REQ));
    end

    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            state          <= S_IDLE;
            mode_q         <= '0;
            k              <= '0;
            gap_cnt        <= '0;
            lat_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            fpga_addr      <= '0;
            fpga_wr_en     <= 1'b0;
            fpga_wr_data   <= '0;
            fpga_rd_en     <= 1'b0;
            fpga_req       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        mode_q         <= mode;
                        k              <= '0;
                        lat_cnt        <= '0;
                        fpga_addr      <= START_ADDR;
                        fpga_wr_data   <= pattern(mode, '0, START_ADDR);
                        fpga_wr_en     <= 1'b1;
                        fpga_req       <= 1'b1;
                        state          <= S_WR_REQ;
                    end
                end
                S_WR_REQ, S_RD_REQ: begin
                    // An ack on the terminal-count cycle wins over the timeout.
                    if (ack_take) begin
                        fpga_req   <= 1'b0;
                        fpga_wr_en <= 1'b0;
                        fpga_rd_en <= 1'b0;
                        gap_cnt    <= GW'(GAP - 1);
                        state      <= (state == S_WR_REQ) ? S_WR_GAP : S_RD_GAP;
                        if ((state == S_RD_REQ) && (fpga_rd_data != expected)) begin
                            err_count <= err_count + EW'(1);
                            if (err_count == '0) begin
                                first_err_addr <= fpga_addr;
                                first_err_data <= fpga_rd_data;
                            end
                        end
                    end else if (tmo_hit) begin
                        fpga_req   <= 1'b0;
                        fpga_wr_en <= 1'b0;
                        fpga_rd_en <= 1'b0;
                        timeout    <= 1'b1;
                        done       <= 1'b1;
                        pass       <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                S_WR_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else begin
                        lat_cnt  <= '0;
                        fpga_req <= 1'b1;
                        if (last_word) begin
                            k            <= '0;
                            fpga_addr    <= START_ADDR;
                            fpga_wr_data <= '0;
                            fpga_rd_en   <= 1'b1;
                            state        <= S_RD_REQ;
                        end else begin
                            k            <= k_next;
                            fpga_addr    <= addr_next;
                            fpga_wr_data <= pattern(mode_q, k_next, addr_next);
                            fpga_wr_en   <= 1'b1;
                            state        <= S_WR_REQ;
                        end
                    end
                end
                S_RD_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else if (last_word) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !timeout;
                        state <= S_DONE;
                    end else begin
                        lat_cnt    <= '0;
                        k          <= k_next;
                        fpga_addr  <= addr_next;
                        fpga_rd_en <= 1'b1;
                        fpga_req   <= 1'b1;
                        state      <= S_RD_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SDRAM_TG_LAT_STATS_EN
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            max_latency  <= '0;
            total_cycles <= '0;
        end else if (accept) begin
            max_latency  <= '0;
            total_cycles <= '0;
        end else begin
            if (ack_take && (lat_cnt > max_latency))
                max_latency <= lat_cnt;
            if (busy && (total_cycles != '1))
                total_cycles <= total_cycles + 32'd1;
        end
    end
`endif

endmodule
